// File: rtl/zigzag_block_scheduler_pkg.sv
// Shared constants, FSM state type and position helper for the zigzag block scheduler.
package zigzag_block_scheduler_pkg;

   localparam int BLOCK_SIZE = 64;
   localparam int COEF_W     = 12;
   localparam int RUN_W      = 6;
   localparam int POS_W      = 7;
   localparam int COMP_W     = 2;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Position after a token: pos + run + 1 (7 bits, never wraps for pos < 64).
   function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] pos,
                                                 input logic [RUN_W-1:0] run);
      return pos + {1'b0, run} + 7'd1;
   endfunction

endpackage

// File: rtl/zigzag_block_scheduler_round_robin_arbiter.sv
// Round-robin arbiter: picks a requester when a block starts and keeps that
// grant for the whole block; the pointer moves past the winner on block end.
module zigzag_block_scheduler_round_robin_arbiter
   import zigzag_block_scheduler_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req,
   input  logic              load,
   input  logic              advance,
   output logic [N_REQ-1:0]  grant,
   output logic [COMP_W-1:0] grant_idx
);

   logic [COMP_W-1:0] ptr;
   logic              hi_found;
   logic [COMP_W-1:0] hi_idx;
   logic              lo_found;
   logic [COMP_W-1:0] lo_idx;
   logic [COMP_W-1:0] pick_idx;

   // Lowest requester at or above the pointer wins, else lowest requester overall.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_found = 1'b0;
      lo_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         lo_found = lo_found | req[i];
         lo_idx   = req[i] ? COMP_W'(i) : lo_idx;
         hi_found = hi_found | (req[i] & (COMP_W'(i) >= ptr));
         hi_idx   = (req[i] && (COMP_W'(i) >= ptr)) ? COMP_W'(i) : hi_idx;
      end
      pick_idx = hi_found ? hi_idx : lo_idx;
   end

   // Grant capture at block start and pointer rotation at block end.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant     <= '0;
         grant_idx <= '0;
         ptr       <= '0;
      end else begin
         if (load && lo_found) begin
            grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            grant_idx <= pick_idx;
         end
         if (advance) begin
            ptr <= (grant_idx == COMP_W'(N_REQ - 1)) ? '0 : grant_idx + COMP_W'(1);
         end
      end
   end

endmodule

// File: rtl/zigzag_block_scheduler.sv
// Zigzag block scheduler: grants one coefficient stream per block, tracks the
// zigzag position, converts end-of-block markers and paces block endings.
module zigzag_block_scheduler
   import zigzag_block_scheduler_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int BLOCK_GAP = 12
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [N_REQ-1:0]          req_valid_in,
   output logic [N_REQ-1:0]          req_ready_out,
   input  logic [N_REQ*RUN_W-1:0]    req_run_in,
   input  logic [N_REQ*COEF_W-1:0]   req_value_in,
   input  logic [N_REQ-1:0]          req_eob_in,
   output logic [RUN_W-1:0]          run_out,
   output logic [COEF_W-1:0]         value_out,
   output logic                      valid_out,
   output logic                      block_start_out,
   output logic [COMP_W-1:0]         block_comp_out,
   output logic                      err_out
);

   localparam int GAP_W = (BLOCK_GAP > 1) ? $clog2(BLOCK_GAP) : 1;

   state_t            state;
   state_t            state_nxt;
   logic [POS_W-1:0]  pos;
   logic [GAP_W-1:0]  gap;
   logic [N_REQ-1:0]  grant;
   logic [COMP_W-1:0] grant_idx;

   logic              sel_valid;
   logic              sel_eob;
   logic [RUN_W-1:0]  sel_run;
   logic [COEF_W-1:0] sel_value;
   logic [POS_W-1:0]  pos_next;
   logic              ends;
   logic              overrun;
   logic              load;
   logic              ready_ok;
   logic              xfer;
   logic              block_end;

   zigzag_block_scheduler_round_robin_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .clk       (clk_in),
      .rst       (rst_in),
      .req       (req_valid_in),
      .load      (load),
      .advance   (block_end),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Select the granted requester's token with a one-hot AND-OR mux.
   always_comb begin
      sel_valid = 1'b0;
      sel_eob   = 1'b0;
      sel_run   = '0;
      sel_value = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_valid = sel_valid | (req_valid_in[i] & grant[i]);
         sel_eob   = sel_eob | (req_eob_in[i] & grant[i]);
         sel_run   = sel_run | (req_run_in[i*RUN_W +: RUN_W] & {RUN_W{grant[i]}});
         sel_value = sel_value | (req_value_in[i*COEF_W +: COEF_W] & {COEF_W{grant[i]}});
      end
   end

   assign pos_next = next_pos(pos, sel_run);
   assign ends     = sel_eob | (pos_next >= POS_W'(BLOCK_SIZE));
   assign overrun  = ~sel_eob & (pos_next > POS_W'(BLOCK_SIZE));

   // Next state, grant load and ready gating; block-ending tokens wait for the gap counter.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      ready_ok  = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid_in) begin
               state_nxt = STREAM;
               load      = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         STREAM: begin
            ready_ok = ~(ends & (gap != '0));
            if (sel_valid && ready_ok && ends) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = STREAM;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign xfer          = sel_valid & ready_ok;
   assign block_end     = xfer & ends;
   assign req_ready_out = grant & {N_REQ{ready_ok}};

   // State register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Position, gap counter, sticky overrun flag and the registered output token.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pos             <= '0;
         gap             <= '0;
         err_out         <= 1'b0;
         valid_out       <= 1'b0;
         run_out         <= '0;
         value_out       <= '0;
         block_start_out <= 1'b0;
         block_comp_out  <= '0;
      end else begin
         valid_out <= xfer;
         if (xfer) begin
            run_out         <= sel_eob ? (RUN_W'(BLOCK_SIZE - 1) - pos[RUN_W-1:0]) : sel_run;
            value_out       <= sel_eob ? '0 : sel_value;
            block_start_out <= (pos == '0);
            block_comp_out  <= grant_idx;
            pos             <= ends ? '0 : pos_next;
         end else begin
            run_out         <= '0;
            value_out       <= '0;
            block_start_out <= 1'b0;
            block_comp_out  <= '0;
         end
         if (block_end) begin
            gap <= GAP_W'(BLOCK_GAP - 1);
         end else if (gap != '0) begin
            gap <= gap - GAP_W'(1);
         end
         if (xfer && overrun) begin
            err_out <= 1'b1;
         end
      end
   end

endmodule
